arbiter: RTL and testbench



---
 rtl/arbiter.sv | 59 +++++
 tb/tb_arbiter.sv | 139 +++++++++++++
 2 files changed

// File: rtl/arbiter.sv
// Three-requester, fixed-priority, non-preemptive arbiter built as a Moore FSM.
// Priority for new grants: req[2] (g1) > req[1] (g2) > req[0] (g3).
module arbiter (
  input  logic       clk,
  input  logic       reset,
  input  logic [2:0] req,
  output logic       g1,
  output logic       g2,
  output logic       g3
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    GNT1 = 2'd1,
    GNT2 = 2'd2,
    GNT3 = 2'd3
  } state_e;

  state_e stateQ;
  state_e stateD;
  state_e pickD;

  always_ff @(posedge clk) begin
    if (!reset) begin
      stateQ <= IDLE;
    end else begin
      stateQ <= stateD;
    end
  end

  // Highest-priority requester currently asking; IDLE when nobody is.
  always_comb begin
    pickD = IDLE;
    if (req[2]) begin
      pickD = GNT1;
    end else if (req[1]) begin
      pickD = GNT2;
    end else if (req[0]) begin
      pickD = GNT3;
    end
  end

  // The owner keeps the grant while its own request stays high; otherwise
  // re-arbitrate in the same cycle so there is no idle bubble.
  always_comb begin
    stateD = pickD;
    case (stateQ)
      GNT1:    if (req[2]) stateD = GNT1;
      GNT2:    if (req[1]) stateD = GNT2;
      GNT3:    if (req[0]) stateD = GNT3;
      default: stateD = pickD;
    endcase
  end

  assign g1 = (stateQ == GNT1);
  assign g2 = (stateQ == GNT2);
  assign g3 = (stateQ == GNT3);

endmodule

// File: tb/tb_arbiter.sv
// Self-checking bench for arbiter: a requester-number model is compared on
// every cycle, plus directed steps with hand-computed grant vectors.
module tb_arbiter;

  logic       clk;
  logic       reset;
  logic [2:0] req;
  logic       g1;
  logic       g2;
  logic       g3;

  int checks;
  int passes;

  // Model state: 0 means nobody owns the resource, otherwise requester 1..3.
  int owner;
  bit modelValid;

  arbiter dut (
    .clk   (clk),
    .reset (reset),
    .req   (req),
    .g1    (g1),
    .g2    (g2),
    .g3    (g3)
  );

  always #5 clk = ~clk;

  function automatic bit wants(input logic [2:0] r, input int n);
    return r[3 - n];
  endfunction

  function automatic int highestRequester(input logic [2:0] r);
    for (int n = 1; n <= 3; n++) begin
      if (wants(r, n)) return n;
    end
    return 0;
  endfunction

  function automatic logic [2:0] grantsFor(input int who);
    logic [2:0] v;
    v = 3'b000;
    if (who != 0) v[3 - who] = 1'b1;
    return v;
  endfunction

  always @(posedge clk) begin
    if (reset !== 1'b1) begin
      owner = 0;
      modelValid = 1'b1;
    end else if (modelValid) begin
      if (owner == 0 || !wants(req, owner)) owner = highestRequester(req);
    end
  end

  // Every-cycle comparison against the model, away from the active edge.
  always @(negedge clk) begin
    if (modelValid) begin
      checks++;
      if ({g1, g2, g3} === grantsFor(owner)) begin
        passes++;
      end else begin
        $display("[TB] FAIL model: grants=%b expected=%b (owner %0d, req=%b)",
                 {g1, g2, g3}, grantsFor(owner), owner, req);
      end
    end
  end

  task automatic applyStimulus(input logic rst, input logic [2:0] r);
    @(negedge clk);
    reset = rst;
    req   = r;
    @(posedge clk);
    #2;
  endtask

  task automatic checkOutput(input string name, input logic [2:0] expected);
    checks++;
    if ({g1, g2, g3} === expected) begin
      passes++;
    end else begin
      $display("[TB] FAIL %s: grants=%b expected=%b", name, {g1, g2, g3}, expected);
    end
  endtask

  initial begin
    clk        = 1'b0;
    reset      = 1'b0;
    req        = 3'b000;
    checks     = 0;
    passes     = 0;
    owner      = 0;
    modelValid = 1'b0;

    applyStimulus(1'b0, 3'b111); checkOutput("reset edge 1", 3'b000);
    applyStimulus(1'b0, 3'b111); checkOutput("reset edge 2", 3'b000);

    applyStimulus(1'b1, 3'b001); checkOutput("first grant g3", 3'b001);
    applyStimulus(1'b1, 3'b001); checkOutput("g3 held", 3'b001);

    applyStimulus(1'b1, 3'b000); checkOutput("back to idle", 3'b000);
    applyStimulus(1'b1, 3'b111); checkOutput("priority from idle", 3'b100);
    applyStimulus(1'b1, 3'b011); checkOutput("handoff to g2", 3'b010);
    applyStimulus(1'b1, 3'b001); checkOutput("handoff to g3", 3'b001);

    applyStimulus(1'b1, 3'b001); checkOutput("g3 hold", 3'b001);
    for (int i = 0; i < 3; i++) begin
      applyStimulus(1'b1, 3'b111); checkOutput("non-preempt", 3'b001);
    end
    applyStimulus(1'b1, 3'b110); checkOutput("g3 release to g1", 3'b100);

    applyStimulus(1'b1, 3'b010); checkOutput("g1 release to g2", 3'b010);
    applyStimulus(1'b1, 3'b000); checkOutput("g2 release to idle", 3'b000);
    applyStimulus(1'b1, 3'b010); checkOutput("g2 from idle", 3'b010);

    applyStimulus(1'b1, 3'b100); checkOutput("g1 after g2", 3'b100);
    applyStimulus(1'b0, 3'b100); checkOutput("reset mid-grant", 3'b000);
    applyStimulus(1'b1, 3'b100); checkOutput("resume after reset", 3'b100);

    // Random traffic; requests tend to persist so grants are held a while.
    for (int i = 0; i < 400; i++) begin
      logic [2:0] r;
      logic       rst;
      r = req;
      for (int b = 0; b < 3; b++) begin
        if ($urandom_range(0, 3) == 0) r[b] = ~r[b];
      end
      rst = ($urandom_range(0, 39) != 0);
      applyStimulus(rst, r);
    end

    @(negedge clk);
    #1;
    $display("[TB] %0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
